// File: rtl/i2c_cmd_sequencer.sv
// Command/response sequencer in front of an I2C master engine: queues write commands,
// launches them one at a time with a busy-flag watchdog and queues one response per command.
module i2c_cmd_sequencer #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid_i,
    output logic                          cmd_ready_o,
    input  logic [6:0]                    cmd_addr_i,
    input  logic [7:0]                    cmd_data_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic                          rsp_ack_o,
    output logic [7:0]                    rsp_data_o,
    output logic                          rsp_err_o,
    output logic [6:0]                    m_slave_addr_o,
    output logic [7:0]                    m_data_in_o,
    output logic                          m_start_o,
    input  logic                          m_busy_i,
    input  logic                          m_ack_i,
    input  logic [7:0]                    m_data_out_i,
    output logic                          seq_busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   cmd_level_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TimerMax = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWaitBusy,
        StWaitDone,
        StPush
    } state_e;

    state_e          state_q;
    logic [TW-1:0]   timer_q;
    logic            m_start_q;
    logic [6:0]      addr_q;
    logic [7:0]      wdata_q;
    logic            ack_q;
    logic [7:0]      rdata_q;
    logic            err_q;

    logic [14:0]     cmd_mem_q [FIFO_DEPTH];
    logic [AW:0]     cmd_wptr_q, cmd_rptr_q;
    logic [9:0]      rsp_mem_q [FIFO_DEPTH];
    logic [AW:0]     rsp_wptr_q, rsp_rptr_q;

    logic            cmd_full, cmd_empty, cmd_push, cmd_pop;
    logic            rsp_full, rsp_empty, rsp_push, rsp_pop;
    logic [9:0]      rsp_head;

    always_comb begin
        cmd_full  = (cmd_wptr_q[AW] != cmd_rptr_q[AW]) &&
                    (cmd_wptr_q[AW-1:0] == cmd_rptr_q[AW-1:0]);
        cmd_empty = (cmd_wptr_q == cmd_rptr_q);
        rsp_full  = (rsp_wptr_q[AW] != rsp_rptr_q[AW]) &&
                    (rsp_wptr_q[AW-1:0] == rsp_rptr_q[AW-1:0]);
        rsp_empty = (rsp_wptr_q == rsp_rptr_q);
        cmd_push  = cmd_valid_i && !cmd_full;
        // A pop in IDLE reserves the response slot for the whole transaction.
        cmd_pop   = (state_q == StIdle) && !cmd_empty && !rsp_full;
        rsp_push  = (state_q == StPush);
        rsp_pop   = !rsp_empty && rsp_ready_i;
        rsp_head  = rsp_mem_q[rsp_rptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_wptr_q <= '0;
            cmd_rptr_q <= '0;
            rsp_wptr_q <= '0;
            rsp_rptr_q <= '0;
        end else begin
            if (cmd_push) cmd_wptr_q <= cmd_wptr_q + 1'b1;
            if (cmd_pop)  cmd_rptr_q <= cmd_rptr_q + 1'b1;
            if (rsp_push) rsp_wptr_q <= rsp_wptr_q + 1'b1;
            if (rsp_pop)  rsp_rptr_q <= rsp_rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (cmd_push) cmd_mem_q[cmd_wptr_q[AW-1:0]] <= {cmd_addr_i, cmd_data_i};
        if (rsp_push) rsp_mem_q[rsp_wptr_q[AW-1:0]] <= {ack_q, rdata_q, err_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            timer_q   <= '0;
            m_start_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ack_q     <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_pop) begin
                        {addr_q, wdata_q} <= cmd_mem_q[cmd_rptr_q[AW-1:0]];
                        m_start_q         <= 1'b1;
                        state_q           <= StLaunch;
                    end
                end
                StLaunch: begin
                    m_start_q <= 1'b0;
                    timer_q   <= '0;
                    state_q   <= StWaitBusy;
                end
                StWaitBusy: begin
                    if (m_busy_i) begin
                        timer_q <= '0;
                        state_q <= StWaitDone;
                    end else if (timer_q == TimerMax) begin
                        ack_q   <= 1'b0;
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        state_q <= StPush;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                StWaitDone: begin
                    if (!m_busy_i) begin
                        ack_q   <= m_ack_i;
                        rdata_q <= m_data_out_i;
                        err_q   <= 1'b0;
                        state_q <= StPush;
                    end else if (timer_q == TimerMax) begin
                        ack_q   <= 1'b0;
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        state_q <= StPush;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                StPush: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Head fields are forced to zero while the response FIFO is empty.
    always_comb begin
        cmd_ready_o    = !cmd_full;
        cmd_level_o    = cmd_wptr_q - cmd_rptr_q;
        rsp_valid_o    = !rsp_empty;
        rsp_ack_o      = rsp_head[9] & !rsp_empty;
        rsp_data_o     = rsp_head[8:1] & {8{!rsp_empty}};
        rsp_err_o      = rsp_head[0] & !rsp_empty;
        m_slave_addr_o = addr_q;
        m_data_in_o    = wdata_q;
        m_start_o      = m_start_q;
        seq_busy_o     = (state_q != StIdle);
    end

endmodule
